pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Payload is an opaque bit vector. The block adds a valid bit, configurable bubble value and multi-cycle-op state hold.
- Flush also clears the carried multi-cycle state, not just the payload.
- Saturating per-stage performance counters (stall, bubble, flush) are exported to the debug/CP0 side.

Parameters:
- DATA_W, 160, payload width in bits.
- STATE_W, 66, multi-cycle-op state width (2-bit count + 64-bit HI/LO accumulator by default).
- STALL_W, 6, width of the global stall vector.
- STAGE_IDX, 3, stall bit that gates this stage's input. Legal range 0..STALL_W-2.
- BUBBLE_VAL, {DATA_W{1'b0}}, payload driven downstream when a bubble is inserted.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- up_payload  in  DATA_W  payload from the upstream stage.
- up_valid  in  1  upstream payload holds a real instruction.
- stall  in  STALL_W  global stall vector from the controller (1 = stop).
- flush  in  1  exception/eret flush.
- state_i  in  STATE_W  multi-cycle-op state produced this cycle by the upstream stage.
- perf_clr  in  1  clears all performance counters.
- dn_payload  out  DATA_W  registered payload to the downstream stage.
- dn_valid  out  1  registered valid bit.
- state_o  out  STATE_W  registered multi-cycle state, fed back to the upstream stage.
- occ_state  out  2  status: 00 EMPTY, 01 FULL, 10 HELD.
- stall_cnt  out  CNT_W  cycles spent in bubble or hold.
- bubble_cnt  out  CNT_W  bubbles inserted.
- flush_cnt  out  CNT_W  flushes taken.

Behaviour:
- Terms used below:
  - s_in = stall[STAGE_IDX].
  - s_out = stall[STAGE_IDX+1].
- All registers update on posedge clk. Latency is 1 cycle from input to output.
- Per-cycle priority: rst > flush > bubble > advance > hold.
- rst:
  - dn_payload = BUBBLE_VAL, dn_valid = 0, state_o = 0, occ_state = EMPTY.
  - All counters = 0.
  - Reset during a multi-cycle op discards that op's state.
- flush:
  - Same register values as reset, except the counters: flush_cnt increments, stall_cnt and bubble_cnt are held.
  - Flush also clears state_o, so a MADD/MSUB in progress is aborted.
- bubble (s_in = 1, s_out = 0):
  - dn_payload = BUBBLE_VAL, dn_valid = 0, state_o = state_i.
  - occ_state = EMPTY.
  - bubble_cnt and stall_cnt each increment.
- advance (s_in = 0):
  - dn_payload = up_payload, dn_valid = up_valid, state_o = 0.
  - occ_state = FULL if up_valid is 1, otherwise EMPTY.
- hold (s_in = 1, s_out = 1):
  - dn_payload and dn_valid are held; state_o = state_i.
  - occ_state = HELD if dn_valid is 1, otherwise EMPTY.
  - stall_cnt increments.
- State transitions:
  - EMPTY → FULL on advance with up_valid = 1.
  - FULL → HELD on hold.
  - HELD → FULL on advance with up_valid = 1.
  - HELD → EMPTY on bubble or flush.
  - Any state → EMPTY on flush or rst.
- Counters:
  - Unsigned and saturating at 2^CNT_W − 1; they never wrap.
  - perf_clr zeroes all counters in the same cycle. perf_clr takes priority over an increment in that cycle.
  - Flush and perf_clr in the same cycle: flush_cnt ends at 0.
- The stall vector is assumed monotonic (stall[k] = 1 implies stall[j] = 1 for all j < k). The block does not check this.
- No combinational path from any input to any output.

Decomposition:
- Shared package pipe_pkg holds:
  - stall-vector constants: STOP = 1, NOSTOP = 0;
  - stage indices IF = 1, ID = 2, EX = 3, MEM = 4, WB = 5;
  - occ_state encodings EMPTY, FULL, HELD;
  - default widths: register 32, HI/LO 64.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) is instantiated three times for the performance counters.

Test Plan:
- Reset and advance:
  - Stimulus: rst = 1 for 2 cycles, then stall = 0, up_payload = 0xA5 (zero-extended), up_valid = 1.
  - Response: during reset dn_valid = 0 and all counters = 0. One cycle after release, dn_payload = 0xA5, dn_valid = 1, occ_state = FULL.
- Bubble:
  - Stimulus: stall = 6'b001111 (STAGE_IDX = 3) for 2 cycles, state_i = {2'b01, 64'h1234}.
  - Response: dn_valid = 0, dn_payload = BUBBLE_VAL, state_o = {2'b01, 64'h1234}, bubble_cnt = 2, stall_cnt = 2.
- Hold:
  - Stimulus: with payload 0x77 registered, apply stall = 6'b011111 for 3 cycles.
  - Response: dn_payload stays 0x77, occ_state = HELD, stall_cnt = 3, bubble_cnt unchanged.
- Flush during multi-cycle op:
  - Stimulus: after the bubble case, state_o = {2'b01, 64'h1234}; assert flush = 1 together with stall = 6'b001111.
  - Response: next cycle state_o = 0, dn_valid = 0, flush_cnt = 1, bubble_cnt not incremented.
- Counter saturation and clear:
  - Stimulus: CNT_W = 4, hold stall for 20 cycles, then pulse perf_clr together with a further hold cycle.
  - Response: stall_cnt stops at 15, then reads 0 after the clear cycle.
- Advance releases state:
  - Stimulus: stall = 0 after a bubble with state_i nonzero.
  - Response: state_o = 0 on the next cycle and dn_payload = up_payload.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants: stall-vector polarity, stage indices,
// occupancy encodings, default datapath widths, and the per-cycle
// operation selected by a stage register.
package pipe_pkg;

  // Stall-vector bit polarity
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Stage indices into the global stall vector
  localparam int IF  = 1;
  localparam int ID  = 2;
  localparam int EX  = 3;
  localparam int MEM = 4;
  localparam int WB  = 5;

  // Default datapath widths
  localparam int REG_W  = 32;
  localparam int HILO_W = 64;

  // Stage occupancy, exported as a status field
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    HELD  = 2'b10
  } occ_t;

  // Operation a stage register performs in a given cycle (reset is handled separately)
  typedef enum logic [1:0] {
    OP_FLUSH,
    OP_BUBBLE,
    OP_ADVANCE,
    OP_HOLD
  } stage_op_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream bus of one pipeline stage register.
//   master : the side that drives upstream payload, stall, flush and state_i
//   slave  : the stage register itself, which drives the registered outputs
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 160,
  parameter int STATE_W = 66,
  parameter int STALL_W = 6
);
  logic [DATA_W-1:0]  up_payload;
  logic               up_valid;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [STATE_W-1:0] state_i;
  logic [DATA_W-1:0]  dn_payload;
  logic               dn_valid;
  logic [STATE_W-1:0] state_o;

  modport master (
    output up_payload, up_valid, stall, flush, state_i,
    input  dn_payload, dn_valid, state_o
  );

  modport slave (
    input  up_payload, up_valid, stall, flush, state_i,
    output dn_payload, dn_valid, state_o
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the per-stage performance counters.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear; takes priority over inc
//   inc      : count one event this cycle
//   q        : count value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (inc && (q != {W{1'b1}}))
      q <= q + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid bit, bubble insertion,
// multi-cycle-op state hold/feedback and saturating perf counters.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : upstream payload/valid/state_i, stall vector, flush in;
//                registered dn_payload/dn_valid/state_o out
//   perf_clr   : clears all perf counters (wins over increments)
//   occ_state  : EMPTY / FULL / HELD
//   stall_cnt  : cycles spent in bubble or hold
//   bubble_cnt : bubbles inserted
//   flush_cnt  : flushes taken
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W     = 160,
  parameter int              STATE_W    = 66,
  parameter int              STALL_W    = 6,
  parameter int              STAGE_IDX  = 3,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus,
  input  logic             perf_clr,
  output logic [1:0]       occ_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [DATA_W-1:0]  r_payload, w_payload_nxt;
  logic               r_valid,   w_valid_nxt;
  logic [STATE_W-1:0] r_state,   w_state_nxt;
  occ_t               r_occ,     w_occ_nxt;
  stage_op_t          w_op;
  logic               w_s_in, w_s_out;

  assign w_s_in  = bus.stall[STAGE_IDX];
  assign w_s_out = bus.stall[STAGE_IDX+1];

  // Priority below reset: flush > bubble > advance > hold
  always_comb begin
    if (bus.flush)      w_op = OP_FLUSH;
    else if (!w_s_in)   w_op = OP_ADVANCE;
    else if (!w_s_out)  w_op = OP_BUBBLE;
    else                w_op = OP_HOLD;
  end

  always_comb begin
    w_payload_nxt = r_payload;
    w_valid_nxt   = r_valid;
    w_state_nxt   = r_state;
    w_occ_nxt     = r_occ;
    case (w_op)
      OP_FLUSH: begin
        // Clearing state_o aborts any multi-cycle op in progress
        w_payload_nxt = BUBBLE_VAL;
        w_valid_nxt   = 1'b0;
        w_state_nxt   = '0;
        w_occ_nxt     = EMPTY;
      end
      OP_BUBBLE: begin
        w_payload_nxt = BUBBLE_VAL;
        w_valid_nxt   = 1'b0;
        w_state_nxt   = bus.state_i;
        w_occ_nxt     = EMPTY;
      end
      OP_ADVANCE: begin
        // Instruction leaves the upstream stage: its op state is done
        w_payload_nxt = bus.up_payload;
        w_valid_nxt   = bus.up_valid;
        w_state_nxt   = '0;
        w_occ_nxt     = bus.up_valid ? FULL : EMPTY;
      end
      default: begin  // OP_HOLD
        w_state_nxt = bus.state_i;
        w_occ_nxt   = r_valid ? HELD : EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_payload <= BUBBLE_VAL;
      r_valid   <= 1'b0;
      r_state   <= '0;
      r_occ     <= EMPTY;
    end else begin
      r_payload <= w_payload_nxt;
      r_valid   <= w_valid_nxt;
      r_state   <= w_state_nxt;
      r_occ     <= w_occ_nxt;
    end
  end

  assign bus.dn_payload = r_payload;
  assign bus.dn_valid   = r_valid;
  assign bus.state_o    = r_state;
  assign occ_state      = r_occ;

  logic w_inc_stall, w_inc_bubble, w_inc_flush;
  assign w_inc_stall  = (w_op == OP_BUBBLE) || (w_op == OP_HOLD);
  assign w_inc_bubble = (w_op == OP_BUBBLE);
  assign w_inc_flush  = (w_op == OP_FLUSH);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(w_inc_stall),  .q(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(w_inc_bubble), .q(bubble_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(w_inc_flush),  .q(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes the hand-computed
// expected outputs for each driven cycle; a monitor pops and compares
// just after the capturing clock edge.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 160;
  localparam int SW = 66;
  localparam int KW = 6;
  localparam int CW = 4;
  localparam logic [DW-1:0] BV = 160'hDEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          perf_clr = 1'b0;
  logic [1:0]    occ_state;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  pipe_stage_reg_if #(.DATA_W(DW), .STATE_W(SW), .STALL_W(KW)) bus ();

  pipe_stage_reg #(
    .DATA_W(DW), .STATE_W(SW), .STALL_W(KW), .STAGE_IDX(3),
    .BUBBLE_VAL(BV), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .perf_clr(perf_clr),
    .occ_state(occ_state), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] d;
    logic          v;
    logic [SW-1:0] s;
    logic [1:0]    o;
    logic [CW-1:0] sc, bc, fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input string fld,
                     input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", name, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge and queue the
  // outputs expected after the next rising edge.
  task automatic step(input string name, input logic r, input logic [KW-1:0] st,
                      input logic fl, input logic v, input logic [DW-1:0] pl,
                      input logic [SW-1:0] si, input logic clr,
                      input logic [DW-1:0] ed, input logic ev, input logic [SW-1:0] es,
                      input logic [1:0] eo, input int esc, input int ebc, input int efc);
    exp_t e;
    @(negedge clk);
    rst = r; bus.stall = st; bus.flush = fl; bus.up_valid = v;
    bus.up_payload = pl; bus.state_i = si; perf_clr = clr;
    e.name = name; e.d = ed; e.v = ev; e.s = es; e.o = eo;
    e.sc = CW'(esc); e.bc = CW'(ebc); e.fc = CW'(efc);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.name, "dn_payload", bus.dn_payload, e.d);
        chk(e.name, "dn_valid",   DW'(bus.dn_valid), DW'(e.v));
        chk(e.name, "state_o",    DW'(bus.state_o),  DW'(e.s));
        chk(e.name, "occ_state",  DW'(occ_state),    DW'(e.o));
        chk(e.name, "stall_cnt",  DW'(stall_cnt),    DW'(e.sc));
        chk(e.name, "bubble_cnt", DW'(bubble_cnt),   DW'(e.bc));
        chk(e.name, "flush_cnt",  DW'(flush_cnt),    DW'(e.fc));
      end
    end
  end

  localparam logic [KW-1:0] NOST = 6'b000000;
  localparam logic [KW-1:0] BUB  = 6'b001111;
  localparam logic [KW-1:0] HLD  = 6'b011111;
  localparam logic [SW-1:0] S1234 = {2'b01, 64'h1234};

  initial begin : stim
    int sc;
    bus.stall = '0; bus.flush = 1'b0; bus.up_valid = 1'b0;
    bus.up_payload = '0; bus.state_i = '0;

    // Reset wins over advance, flush and bubble
    step("rst0", 1, NOST, 0, 1, 'hA5, 0, 0, BV, 0, 0, EMPTY, 0, 0, 0);
    step("rst1", 1, BUB,  1, 1, 'hA5, S1234, 0, BV, 0, 0, EMPTY, 0, 0, 0);
    step("adv",  0, NOST, 0, 1, 'hA5, 0, 0, 'hA5, 1, 0, FULL, 0, 0, 0);
    // Bubble carries upstream multi-cycle state
    step("bub0", 0, BUB,  0, 1, 'h55, S1234, 0, BV, 0, S1234, EMPTY, 1, 1, 0);
    step("bub1", 0, BUB,  0, 1, 'h55, S1234, 0, BV, 0, S1234, EMPTY, 2, 2, 0);
    // Flush beats bubble and aborts the op state
    step("flush", 0, BUB, 1, 1, 'h55, S1234, 0, BV, 0, 0, EMPTY, 2, 2, 1);
    step("adv_clr", 0, NOST, 0, 1, 'h77, 5, 1, 'h77, 1, 0, FULL, 0, 0, 0);
    for (int k = 1; k <= 3; k++)
      step("hold", 0, HLD, 0, 1, 'h99, 3, 0, 'h77, 1, 3, HELD, k, 0, 0);
    step("bub2",    0, BUB,  0, 1, 'h99, 9, 0, BV, 0, 9, EMPTY, 4, 1, 0);
    step("adv_rel", 0, NOST, 0, 1, 'h3C, 9, 0, 'h3C, 1, 0, FULL, 4, 1, 0);
    step("adv_inv", 0, NOST, 0, 0, 'h11, 0, 0, 'h11, 0, 0, EMPTY, 4, 1, 0);
    step("hold_e",  0, HLD,  0, 1, 'h22, 2, 0, 'h11, 0, 2, EMPTY, 5, 1, 0);
    // Stall counter saturates at 15 with CNT_W = 4
    for (int k = 1; k <= 20; k++) begin
      sc = (5 + k > 15) ? 15 : 5 + k;
      step("sat", 0, HLD, 0, 1, 'h22, 2, 0, 'h11, 0, 2, EMPTY, sc, 1, 0);
    end
    step("hold_clr",  0, HLD,  0, 1, 'h22, 2, 1, 'h11, 0, 2, EMPTY, 0, 0, 0);
    step("flush2",    0, NOST, 1, 1, 'h22, 2, 0, BV, 0, 0, EMPTY, 0, 0, 1);
    step("flush_clr", 0, NOST, 1, 1, 'h22, 2, 1, BV, 0, 0, EMPTY, 0, 0, 0);
    step("bub3",      0, BUB,  0, 1, 'h22, 7, 0, BV, 0, 7, EMPTY, 1, 1, 0);
    step("rst_mc",    1, BUB,  0, 1, 'h22, 7, 0, BV, 0, 0, EMPTY, 0, 0, 0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
